// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU-op encodings and the EX control bundle.
// Pure declarations, no timing or flow control.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC   = 2'b10;
  localparam logic [1:0] ALU_OP_LUI    = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (opcode)
      OP_R: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_FUNC;
      end
      OP_IMM: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_OP_FUNC;
      end
      OP_LOAD: begin
        c.mem_read   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALU_OP_ADD;
      end
      OP_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.alu_op = ALU_OP_BRANCH;
      end
      OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_OP_LUI;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // {rs2 used, rs1 used}; unused index fields must never trigger a stall
  function automatic logic [1:0] reg_usage(input logic [6:0] opcode);
    logic [1:0] u;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: u = 2'b11;
      OP_IMM, OP_LOAD:           u = 2'b01;
      default:                   u = 2'b00;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: instruction word to sign-extended immediate, purely combinational.
// No state, no flow control.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:       imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI:          imm32 = {instr[31:12], 12'b0};
      default:         imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// Decode + ID/EX register: one-cycle latency, same-cycle WB bypass into the operands.
// Load-use hazard raises stall for one cycle and inserts a bubble; a flush overrides the stall.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instr,
  input  logic [PC_W-1:0] if_id_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            ex_illegal
);

  ctrl_t           dec_ctrl;
  ctrl_t           ex_ctrl;
  logic [1:0]      usage;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            hazard;
  logic            bubble;

  assign rs1_addr = if_id_instr[19:15];
  assign rs2_addr = if_id_instr[24:20];
  assign dec_ctrl = decode_ctrl(if_id_instr[6:0]);
  assign usage    = reg_usage(if_id_instr[6:0]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_id_instr),
    .imm   (imm)
  );

  // The register file writes on the same edge this stage samples, so WB must be bypassed here
  always_comb begin
    if (rs1_addr == 5'd0)
      op1 = '0;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1_addr))
      op1 = wb_data;
    else
      op1 = rf_rd1;

    if (rs2_addr == 5'd0)
      op2 = '0;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2_addr))
      op2 = wb_data;
    else
      op2 = rf_rd2;
  end

  assign hazard = if_id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != 5'd0) &
                  ((usage[0] & (ex_rd == rs1_addr)) | (usage[1] & (ex_rd == rs2_addr)));
  assign stall  = hazard & ~ex_flush;
  assign bubble = ex_flush | stall | ~if_id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || bubble) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_pc       <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
    end else begin
      ex_valid    <= 1'b1;
      ex_ctrl     <= dec_ctrl;
      ex_pc       <= if_id_pc;
      ex_rs1_val  <= op1;
      ex_rs2_val  <= op2;
      ex_imm      <= imm;
      ex_rs1      <= rs1_addr;
      ex_rs2      <= rs2_addr;
      ex_rd       <= if_id_instr[11:7];
      ex_funct3   <= if_id_instr[14:12];
      ex_funct7b5 <= if_id_instr[30];
    end
  end

  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_illegal    = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage against a field-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_illegal;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [1:0]  aop;
    logic        asrc, mr, mw, rw, m2r, br, ill;
  } slot_t;

  slot_t exp_s;
  int    tests = 0;
  int    fails = 0;
  logic  last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] sext(input longint v, input int bits);
    longint r;
    r = v;
    if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
    return 32'(r);
  endfunction

  function automatic logic [1:0] uses(input logic [6:0] op);
    if (op == 7'h33 || op == 7'h23 || op == 7'h63) return 2'b11;
    if (op == 7'h13 || op == 7'h03) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf,
                                          input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd);
    if (idx == 0) return 32'd0;
    if (wbw && wbrd == idx) return wbd;
    return rf;
  endfunction

  function automatic slot_t predict(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rd1,
                                    input logic [31:0] rd2, input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd);
    slot_t s;
    s = '0;
    s.valid = 1'b1;
    s.pc    = pc;
    s.rs1   = instr[19:15];
    s.rs2   = instr[24:20];
    s.rd    = instr[11:7];
    s.f3    = instr[14:12];
    s.f7    = instr[30];
    s.v1    = operand(instr[19:15], rd1, wbw, wbrd, wbd);
    s.v2    = operand(instr[24:20], rd2, wbw, wbrd, wbd);
    case (instr[6:0])
      7'h33: begin s.rw = 1; s.aop = 2; end
      7'h13: begin s.rw = 1; s.asrc = 1; s.aop = 2; s.imm = sext(longint'(instr[31:20]), 12); end
      7'h03: begin s.mr = 1; s.rw = 1; s.m2r = 1; s.asrc = 1; s.aop = 0; s.imm = sext(longint'(instr[31:20]), 12); end
      7'h23: begin s.mw = 1; s.asrc = 1; s.aop = 0;
                   s.imm = sext(longint'(instr[31:25]) * 32 + longint'(instr[11:7]), 12); end
      7'h63: begin s.br = 1; s.aop = 1;
                   s.imm = sext(longint'(instr[31]) * 4096 + longint'(instr[7]) * 2048 +
                                longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2, 13); end
      7'h37: begin s.rw = 1; s.asrc = 1; s.aop = 3; s.imm = 32'(longint'(instr[31:12]) * 4096); end
      default: s.ill = 1;
    endcase
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(exp_s.valid));
    chk({tag, ".pc"}, ex_pc, exp_s.pc);
    chk({tag, ".rs1_val"}, ex_rs1_val, exp_s.v1);
    chk({tag, ".rs2_val"}, ex_rs2_val, exp_s.v2);
    chk({tag, ".imm"}, ex_imm, exp_s.imm);
    chk({tag, ".ctl"},
        32'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_alu_op, ex_alu_src, ex_mem_read,
             ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_illegal}),
        32'({exp_s.rs1, exp_s.rs2, exp_s.rd, exp_s.f3, exp_s.f7, exp_s.aop, exp_s.asrc, exp_s.mr,
             exp_s.mw, exp_s.rw, exp_s.m2r, exp_s.br, exp_s.ill}));
  endtask

  // Apply one IF/ID cycle, check combinational outputs, then the registered slot after the edge
  task automatic step(input string tag, input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rd1, input logic [31:0] rd2, input logic wbw, input logic [4:0] wbrd,
                      input logic [31:0] wbd, input logic flush);
    slot_t      nxt;
    logic [1:0] u;
    logic       mst;
    if_id_valid = v; if_id_instr = instr; if_id_pc = pc; rf_rd1 = rd1; rf_rd2 = rd2;
    wb_regwrite = wbw; wb_rd = wbrd; wb_data = wbd; ex_flush = flush;
    #1;
    u   = uses(instr[6:0]);
    mst = v && exp_s.valid && exp_s.mr && exp_s.rd != 0 &&
          ((u[0] && exp_s.rd == instr[19:15]) || (u[1] && exp_s.rd == instr[24:20])) && !flush;
    last_stall = stall;
    chk({tag, ".stall"}, 32'(stall), 32'(mst));
    chk({tag, ".rs_addr"}, 32'({rs1_addr, rs2_addr}), 32'({instr[19:15], instr[24:20]}));
    if (!v || flush || mst) nxt = '0;
    else nxt = predict(instr, pc, rd1, rd2, wbw, wbrd, wbd);
    @(posedge clk);
    #1;
    exp_s = nxt;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, rs1, input logic [2:0] f3, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  localparam logic [31:0] LW_X7 = {12'd0, 5'd1, 3'b010, 5'd7, 7'h03};
  localparam logic [31:0] LUI_X7 = {20'hABCDE, 5'd7, 7'h37};

  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h7F, 7'h17, 7'h6F};

  initial begin
    logic [31:0] add_dep;
    logic [31:0] ri;
    add_dep = enc_r(5'd8, 5'd7, 5'd2);
    reset = 1'b1; if_id_valid = 0; if_id_instr = 0; if_id_pc = 0; rf_rd1 = 0; rf_rd2 = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0; ex_flush = 0;
    exp_s = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_init");
    chk("rst_init.stall", 32'(stall), 32'd0);
    reset = 1'b0;

    step("addi", 1, 32'hFF900293, 32'h100, 32'hDEAD, 32'h5, 0, 0, 0, 0);
    chk("addi.imm_const", ex_imm, 32'hFFFFFFF9);
    chk("addi.x0_const", ex_rs1_val, 32'd0);
    chk("addi.alu_src_const", 32'(ex_alu_src), 32'd1);

    // Reset pulse in the middle of a cycle while a valid add sits in IF/ID
    if_id_valid = 1; if_id_instr = enc_r(5'd3, 5'd1, 5'd2); if_id_pc = 32'h104;
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_s = '0;
    check_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset = 1'b0;
    step("add_after_rst", 1, enc_r(5'd3, 5'd1, 5'd2), 32'h104, 32'h11, 32'h22, 0, 0, 0, 0);
    chk("add_after_rst.rd_const", 32'(ex_rd), 32'd3);
    chk("add_after_rst.aop_const", 32'(ex_alu_op), 32'd2);
    chk("add_after_rst.rw_const", 32'(ex_reg_write), 32'd1);

    step("sw_bypass", 1, enc_s(5'd2, 5'd6, 12'hFFC), 32'h108, 32'h50, 32'h9999, 1, 5'd6, 32'h1234, 0);
    chk("sw_bypass.rs2_const", ex_rs2_val, 32'h1234);
    chk("sw_bypass.imm_const", ex_imm, 32'hFFFFFFFC);
    step("sw_nobyp", 1, enc_s(5'd2, 5'd6, 12'hFFC), 32'h10C, 32'h50, 32'h9999, 1, 5'd0, 32'h1234, 0);
    chk("sw_nobyp.rs2_const", ex_rs2_val, 32'h9999);

    step("lw1", 1, LW_X7, 32'h110, 32'h200, 0, 0, 0, 0, 0);
    step("lu_stall", 1, add_dep, 32'h114, 32'h77, 32'h88, 0, 0, 0, 0);
    chk("lu_stall.seen", 32'(last_stall), 32'd1);
    chk("lu_stall.bubble", 32'(ex_valid), 32'd0);
    step("lu_issue", 1, add_dep, 32'h114, 32'h77, 32'h88, 0, 0, 0, 0);
    chk("lu_issue.stall_clear", 32'(last_stall), 32'd0);
    chk("lu_issue.rs1_const", 32'(ex_rs1), 32'd7);

    step("lw2", 1, LW_X7, 32'h118, 32'h200, 0, 0, 0, 0, 0);
    step("lui_nohaz", 1, LUI_X7, 32'h11C, 32'h7, 32'h7, 0, 0, 0, 0);
    chk("lui_nohaz.stall", 32'(last_stall), 32'd0);

    step("lw3", 1, LW_X7, 32'h120, 32'h200, 0, 0, 0, 0, 0);
    step("haz_flush", 1, add_dep, 32'h124, 32'h1, 32'h2, 0, 0, 0, 1);
    chk("haz_flush.stall", 32'(last_stall), 32'd0);
    chk("haz_flush.valid", 32'(ex_valid), 32'd0);

    step("beq", 1, enc_b(5'd1, 5'd2, 13'h1FF8), 32'h128, 32'h3, 32'h4, 0, 0, 0, 0);
    chk("beq.imm_const", ex_imm, 32'hFFFFFFF8);
    chk("beq.branch_const", 32'(ex_branch), 32'd1);

    step("illegal", 1, 32'h1234507F, 32'h12C, 32'h5, 32'h6, 0, 0, 0, 0);
    chk("illegal.flag", 32'(ex_illegal), 32'd1);
    chk("illegal.ctl_zero", 32'({ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                                 ex_mem_to_reg, ex_branch}), 32'd0);

    // Reset arriving while a load-use stall is being signalled
    step("lw4", 1, LW_X7, 32'h130, 32'h200, 0, 0, 0, 0, 0);
    if_id_valid = 1; if_id_instr = add_dep; if_id_pc = 32'h134;
    #1;
    chk("rst_stall.pre", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_stall.stall", 32'(stall), 32'd0);
    chk("rst_stall.valid", 32'(ex_valid), 32'd0);
    exp_s = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs("rst_stall.hold");

    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      ri[6:0]   = ops[$urandom_range(0, 8)];
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      ri[11:7]  = 5'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 99) < 85), ri, $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 99) < 10));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage RV32I pipeline.
- Drives rs1/rs2 addresses to the register file and decodes the IF/ID instruction.
- Bypasses the same-cycle writeback into the operands; the register file writes on the clock edge and reads combinationally, so without the bypass ID would see the old value.
- Detects load-use hazards, stalls upstream and registers operands, immediate and control for the EX stage.

Parameters:
XLEN, 32, datapath width
PC_W, 32, program counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
if_id_valid  in  1  IF/ID holds a real instruction
if_id_instr  in  32  instruction word
if_id_pc  in  PC_W  instruction PC
rs1_addr  out  5  instr[19:15] to register file (combinational)
rs2_addr  out  5  instr[24:20] to register file (combinational)
rf_rd1  in  XLEN  register file ReadData1
rf_rd2  in  XLEN  register file ReadData2
wb_regwrite  in  1  WB stage write enable
wb_rd  in  5  WB destination
wb_data  in  XLEN  WB write data
ex_flush  in  1  taken branch resolved in EX; squash ID
stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  EX slot holds a real instruction
ex_pc  out  PC_W  registered PC
ex_rs1_val, ex_rs2_val  out  XLEN each  registered operands
ex_imm  out  XLEN  sign-extended immediate
ex_rs1, ex_rs2, ex_rd  out  5 each  register indices, for EX forwarding
ex_funct3  out  3  instr[14:12]
ex_funct7b5  out  1  instr[30]
ex_alu_op  out  2  00 add (ld/st), 01 branch compare, 10 R/I function, 11 LUI pass-imm
ex_alu_src  out  1  1 selects ex_imm
ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each  control
ex_illegal  out  1  opcode not supported

Behaviour:
- Reset: all ex_* outputs are 0, asynchronously. stall is 0 because ex_valid=0.
- Latency: one cycle. Values decoded in cycle N appear on ex_* after edge N+1.
- Supported opcodes:
  - R 0110011: reg_write, alu_op 10.
  - I-ALU 0010011: reg_write, alu_src, alu_op 10.
  - Load 0000011: mem_read, reg_write, mem_to_reg, alu_src, alu_op 00.
  - Store 0100011: mem_write, alu_src, alu_op 00.
  - Branch 1100011: branch, alu_op 01.
  - LUI 0110111: reg_write, alu_src, alu_op 11.
- Any other opcode with if_id_valid=1: ex_illegal=1, ex_valid=1, all other control 0.
- Immediates:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - R: 0.
- Register usage:
  - rs1 is used by R, I, Load, Store and Branch.
  - rs2 is used by R, Store and Branch.
  - LUI uses neither.
  - Unused index fields are still registered but never cause a stall.
- Operand select, per port, in priority order:
  1. Index is x0: value 0, even if the register file returns non-zero.
  2. wb_regwrite=1, wb_rd≠0 and wb_rd equals the index: wb_data.
  3. Otherwise the rf value.
- hazard = if_id_valid & ex_valid & ex_mem_read & ex_rd≠0 & ((rs1 used & ex_rd==rs1) | (rs2 used & ex_rd==rs2)).
- stall = hazard & ~ex_flush.
- Register update at each edge, in priority order:
  1. reset
  2. ex_flush: bubble
  3. stall: bubble
  4. if_id_valid=0: bubble
  5. otherwise load the decoded values
- Bubble: ex_valid=0, all control and ex_illegal 0. Data fields are don't-care, but the bench expects 0.
- Stall lasts exactly one cycle per load-use pair. Next cycle the load has moved to MEM, so hazard clears.
- Flush and hazard in the same cycle: flush wins, stall stays 0 and a bubble is inserted.
- Reset asserted mid-stall: outputs clear immediately and stall drops in the same cycle.
- No internal FSM beyond the registered slot.

Decomposition:
- Package rv_pkg: opcode localparams, ALU_OP_* encodings, XLEN default, and the bubble control value as a packed control struct.
- Sub-module imm_gen: combinational, instr → XLEN immediate.
- Operand bypass and hazard logic stay inline.

Test Plan:
- Reset pulse mid-cycle, with if_id_valid=1 holding `add x3,x1,x2` → every ex_* output is 0 during reset. First edge after release: ex_valid=1, ex_rd=3, ex_alu_op=10, ex_reg_write=1.
- `addi x5,x0,-7` (0xFF900293) → ex_imm=0xFFFFFFF9, ex_rs1_val=0 while rf_rd1 is driven 0xDEAD, ex_alu_src=1.
- `sw x6,-4(x2)` with wb_regwrite=1, wb_rd=6, wb_data=0x1234, rf_rd2=0x9999 → ex_rs2_val=0x1234 and ex_imm=0xFFFFFFFC. Repeat with wb_rd=0 → ex_rs2_val=0x9999.
- `lw x7,0(x1)` followed by `add x8,x7,x2` → stall=1 for one cycle and ex_valid=0 on the next edge. The add then issues with ex_rs1=7. `lui x7,..` in place of the add → stall=0.
- Load-use hazard coincident with ex_flush=1 → stall=0 and the next ex_valid is 0.
- `beq x1,x2,-8` → ex_imm=0xFFFFFFF8 and ex_branch=1. Opcode 0x7F → ex_illegal=1 with all control bits 0.
